// File: rtl/uart_frame_pkg.sv
// Shared definitions for the pulse-generator control link framing:
// frame headers, frame length, transmitter state encoding and checksum helper.
package uart_frame_pkg;

    localparam logic [7:0]  ACK_HEADER = 8'h70;
    localparam logic [7:0]  CMD_HEADER = 8'h07;
    localparam int unsigned FRAME_LEN  = 8;
    localparam int unsigned PACER_W    = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } tx_state_t;

    typedef logic [FRAME_LEN-1:0][7:0] frame_t;

    // Modulo-256 sum of every byte except the last (checksum slot).
    function automatic logic [7:0] frame_checksum(input frame_t f);
        logic [7:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < FRAME_LEN - 1; i++) begin
            sum = sum + f[3'(i)];
        end
        return sum;
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Request/configuration inputs and uart_tx-facing byte stream of the
// acknowledge-frame transmitter.
interface uart_frame_tx_if;

    logic       send_req;
    logic [7:0] cmd_echo;
    logic [6:0] pulse_width1;
    logic [6:0] pulse_width2;
    logic [6:0] pulse_gap;
    logic [6:0] status_in;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic       busy;
    logic       frame_done;

    modport master (
        output send_req, cmd_echo, pulse_width1, pulse_width2, pulse_gap, status_in,
        input  pi_data, pi_flag, busy, frame_done
    );

    modport slave (
        input  send_req, cmd_echo, pulse_width1, pulse_width2, pulse_gap, status_in,
        output pi_data, pi_flag, busy, frame_done
    );

endinterface

// File: rtl/uart_frame_tx_byte_pacer.sv
// Byte spacing timer: a start strobe arms a down-counter for `period` cycles;
// `expire` is high in the last of those cycles.
module byte_pacer
    import uart_frame_pkg::*;
#(
    parameter int unsigned CNT_W = PACER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] period,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;
    logic             running;

    // Load on start, count down while running, stop once zero is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= period - CNT_W'(1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign expire = running && (cnt == '0);

endmodule

// File: rtl/uart_frame_tx.sv
// Acknowledge-frame transmitter: snapshots configuration/status into an
// 8-byte frame and feeds it byte by byte to uart_tx, pacing bytes itself.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int unsigned UART_BPS   = 9600,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned STOP_GUARD = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    uart_frame_tx_if.slave   bus
);

    localparam int unsigned        BYTE_CYCLES_INT = (CLK_FREQ / UART_BPS) * (10 + STOP_GUARD);
    localparam logic [PACER_W-1:0] BYTE_CYCLES     = PACER_W'(BYTE_CYCLES_INT);
    localparam logic [2:0]         LAST_IDX        = 3'(FRAME_LEN - 1);

    tx_state_t  state;
    tx_state_t  next_state;
    frame_t     frame;
    frame_t     body;
    logic [7:0] cksum;
    logic [2:0] idx;
    logic [7:0] seq;
    logic       pend;
    logic       overrun;
    logic       pacer_start;
    logic       pacer_expire;
    logic [7:0] data_hold;
    logic [7:0] pi_data_c;

    byte_pacer #(.CNT_W(PACER_W)) u_pacer (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .start  (pacer_start),
        .period (BYTE_CYCLES),
        .expire (pacer_expire)
    );

    // Frame contents as they would be captured this cycle.
    always_comb begin
        body    = '0;
        body[0] = ACK_HEADER;
        body[1] = bus.cmd_echo;
        body[2] = {1'b0, bus.pulse_width1};
        body[3] = {1'b0, bus.pulse_width2};
        body[4] = {1'b0, bus.pulse_gap};
        body[5] = {overrun, bus.status_in};
        body[6] = seq;
    end

    assign cksum = frame_checksum(body);

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and pacer launch.
    always_comb begin
        next_state  = state;
        pacer_start = 1'b0;
        unique case (state)
            ST_IDLE: if (bus.send_req) next_state = ST_LOAD;
            ST_LOAD: next_state = ST_SEND;
            ST_SEND: begin
                pacer_start = 1'b1;
                next_state  = ST_WAIT;
            end
            ST_WAIT: begin
                if (pacer_expire) begin
                    next_state = (idx == LAST_IDX) ? ST_DONE : ST_SEND;
                end
            end
            ST_DONE: begin
                // A request in DONE is folded into the pending slot and
                // consumed immediately, so it chains without dropping busy.
                next_state = (pend || bus.send_req) ? ST_LOAD : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Frame snapshot, byte index, sequence number, pending/overrun bookkeeping.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame     <= '0;
            idx       <= '0;
            seq       <= '0;
            pend      <= 1'b0;
            overrun   <= 1'b0;
            data_hold <= '0;
        end else begin
            data_hold <= pi_data_c;

            if (state == ST_LOAD) begin
                frame    <= body;
                frame[7] <= cksum;
                idx      <= '0;
                overrun  <= 1'b0;
            end

            if (state == ST_WAIT && pacer_expire && idx != LAST_IDX) begin
                idx <= idx + 3'd1;
            end

            if (state == ST_DONE) begin
                seq  <= seq + 8'd1;
                pend <= 1'b0;
                if (bus.send_req && pend) begin
                    overrun <= 1'b1;
                end
            end else if (state != ST_IDLE && bus.send_req) begin
                if (pend) begin
                    overrun <= 1'b1;
                end else begin
                    pend <= 1'b1;
                end
            end
        end
    end

    assign pi_data_c      = (state == ST_SEND) ? frame[idx] : data_hold;
    assign bus.pi_data    = pi_data_c;
    assign bus.pi_flag    = (state == ST_SEND);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: scoreboard of expected frame bytes,
// byte spacing / latency checks, pending, overrun, snapshot, wrap and reset.
module tb_uart_frame_tx;
    import uart_frame_pkg::*;

    localparam int unsigned CLK_FREQ     = 1_000_000;
    localparam int unsigned UART_BPS     = 500_000;
    localparam int unsigned STOP_GUARD   = 1;
    localparam int unsigned BYTE_CYCLES  = (CLK_FREQ / UART_BPS) * (10 + STOP_GUARD);
    localparam int unsigned FLAG_SPACING = BYTE_CYCLES + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_tx_if bus();

    uart_frame_tx #(
        .UART_BPS   (UART_BPS),
        .CLK_FREQ   (CLK_FREQ),
        .STOP_GUARD (STOP_GUARD)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  m_seq = '0;

    int unsigned cyc = 0;
    int unsigned byte_cnt = 0;
    int unsigned fd_cnt = 0;
    int unsigned pos = 0;
    int unsigned last_flag_cyc = 0;
    int unsigned last_fd_cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned fd_to_start = 0;
    int unsigned busy_low = 0;
    logic [7:0]  hold_exp = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected frame from the current inputs and model sequence number.
    task automatic push_frame(input logic ov);
        logic [7:0] b[8];
        logic [7:0] sum;
        b[0] = 8'h70;
        b[1] = bus.cmd_echo;
        b[2] = {1'b0, bus.pulse_width1};
        b[3] = {1'b0, bus.pulse_width2};
        b[4] = {1'b0, bus.pulse_gap};
        b[5] = {ov, bus.status_in};
        b[6] = m_seq;
        sum = 8'h00;
        for (int i = 0; i < 7; i++) sum = sum + b[i];
        b[7] = sum;
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        m_seq = m_seq + 8'd1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every strobe, checks spacing.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pi_flag) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(bus.pi_data), 32'h100);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", pos), 32'(bus.pi_data), 32'(e));
                end
                if (pos != 0) begin
                    check("flag_spacing", cyc - last_flag_cyc, FLAG_SPACING);
                end else begin
                    start_cyc   = cyc;
                    fd_to_start = cyc - last_fd_cyc;
                end
                hold_exp      = bus.pi_data;
                last_flag_cyc = cyc;
                pos           = (pos + 1) % 8;
                byte_cnt++;
            end else begin
                check("pi_data_hold", 32'(bus.pi_data), 32'(hold_exp));
            end
            if (bus.frame_done) begin
                check("done_timing", cyc - last_flag_cyc, FLAG_SPACING);
                check("done_after_byte7", pos, 0);
                fd_cnt++;
                last_fd_cyc = cyc;
            end
            if (!bus.busy) busy_low++;
        end
    end

    task automatic request();
        @(negedge clk);
        bus.send_req = 1'b1;
        @(negedge clk);
        bus.send_req = 1'b0;
    endtask

    task automatic wait_bytes(input int unsigned n);
        for (int i = 0; i < 4000; i++) begin
            if (byte_cnt >= n) return;
            @(posedge clk);
        end
        check("wait_bytes_timeout", byte_cnt, n);
    endtask

    task automatic wait_frames(input int unsigned n);
        for (int i = 0; i < 6000; i++) begin
            if (fd_cnt >= n) return;
            @(posedge clk);
        end
        check("wait_frames_timeout", fd_cnt, n);
    endtask

    initial begin
        int unsigned base;
        int unsigned bb;
        int unsigned req_cyc;
        int unsigned bl0;
        logic [7:0]  t1[8];

        rst               = 1'b1;
        bus.send_req      = 1'b0;
        bus.cmd_echo      = 8'h07;
        bus.pulse_width1  = 7'h05;
        bus.pulse_width2  = 7'h0A;
        bus.pulse_gap     = 7'h14;
        bus.status_in     = 7'h01;
        repeat (3) @(negedge clk);
        check("rst_pi_data", 32'(bus.pi_data), 0);
        check("rst_pi_flag", 32'(bus.pi_flag), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        rst = 1'b0;

        // Single frame, fixed expected bytes.
        t1 = '{8'h70, 8'h07, 8'h05, 8'h0A, 8'h14, 8'h01, 8'h00, 8'h9B};
        for (int i = 0; i < 8; i++) exp_q.push_back(t1[i]);
        m_seq = 8'd1;
        base = fd_cnt;
        request();
        req_cyc = cyc;
        check("busy_after_req", 32'(bus.busy), 1);
        wait_frames(base + 1);
        check("first_flag_latency", start_cyc - req_cyc, 1);
        repeat (5) @(negedge clk);
        check("single_done_count", fd_cnt, base + 1);
        check("idle_busy", 32'(bus.busy), 0);

        // Snapshot: w1 changes during byte 1.
        push_frame(1'b0);
        bb = byte_cnt;
        base = fd_cnt;
        request();
        wait_bytes(bb + 2);
        @(negedge clk);
        bus.pulse_width1 = 7'h7F;
        wait_frames(base + 1);

        // Pending: second request mid-frame chains a second frame.
        push_frame(1'b0);
        bb = byte_cnt;
        base = fd_cnt;
        request();
        wait_bytes(bb + 3);
        push_frame(1'b0);
        bl0 = busy_low;
        request();
        wait_frames(base + 2);
        check("pend_busy_gap", busy_low - bl0, 0);
        check("pend_start_after_done", fd_to_start, 2);

        // Overrun: three requests during one frame give one extra frame.
        repeat (3) @(negedge clk);
        push_frame(1'b0);
        bb = byte_cnt;
        base = fd_cnt;
        request();
        wait_bytes(bb + 2);
        request();
        request();
        request();
        push_frame(1'b1);
        wait_frames(base + 2);
        repeat (300) @(negedge clk);
        check("overrun_frame_count", fd_cnt, base + 2);
        check("overrun_idle_busy", 32'(bus.busy), 0);
        push_frame(1'b0);
        request();
        wait_frames(base + 3);

        // Sequence wrap: enough frames to pass 0xFF -> 0x00.
        for (int f = 0; f < 257; f++) begin
            push_frame(1'b0);
            base = fd_cnt;
            request();
            wait_frames(base + 1);
        end

        // Reset after byte 3, then a clean restart.
        repeat (3) @(negedge clk);
        push_frame(1'b0);
        bb = byte_cnt;
        request();
        wait_bytes(bb + 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pi_flag", 32'(bus.pi_flag), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_pi_data", 32'(bus.pi_data), 0);
        check("midrst_frame_done", 32'(bus.frame_done), 0);
        exp_q.delete();
        pos      = 0;
        hold_exp = '0;
        m_seq    = '0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        push_frame(1'b0);
        base = fd_cnt;
        request();
        wait_frames(base + 1);
        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
